pipe_trace_unit: RTL and testbench

- Parametrised retirement-trace and instruction-class profiler for the mips_pipeline core, instantiated beside the CPU.
- Samples each valid writeback-stage instruction (PC, instruction word, write data) into a circular trace buffer of DEPTH entries.
- Keeps per-class retirement counters and a cycle budget that ends the run at MAX_CYCLES.
- Buffer contents are drained through a valid/ready read port; any counter is readable through a select port.

---
 rtl/pipe_trace_pkg.sv | 87 ++++++++
 rtl/pipe_trace_unit_ring.sv | 66 ++++++
 rtl/pipe_trace_unit.sv | 111 +++++++++++
 tb/tb_pipe_trace_unit.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the retirement-trace profiler: decoder constants,
// instruction classes, FSM states, the fixed part of a trace entry and the classifier.
package pipe_trace_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_JR    = 6'd8;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [5:0] FN_SLL   = 6'd0;
   localparam logic [5:0] FN_HI    = 6'd10;
   localparam logic [5:0] FN_LO    = 6'd12;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_ADD   = 6'd32;
   localparam logic [5:0] FN_SUB   = 6'd34;
   localparam logic [5:0] FN_AND   = 6'd36;
   localparam logic [5:0] FN_OR    = 6'd37;

   typedef enum logic [3:0] {
      CLS_ADD   = 4'd0,
      CLS_SUB   = 4'd1,
      CLS_AND   = 4'd2,
      CLS_OR    = 4'd3,
      CLS_SLL   = 4'd4,
      CLS_NOP   = 4'd5,
      CLS_MULTU = 4'd6,
      CLS_HI    = 4'd7,
      CLS_LO    = 4'd8,
      CLS_LW    = 4'd9,
      CLS_SW    = 4'd10,
      CLS_BEQ   = 4'd11,
      CLS_J     = 4'd12,
      CLS_JR    = 4'd13,
      CLS_ANDI  = 4'd14,
      CLS_OTHER = 4'd15
   } cls_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Width-independent part of a trace entry; PC, write data and cycle stamp are
   // parameter-sized and packed alongside it by the top level.
   typedef struct packed {
      logic [31:0] instr;
      cls_e        cls;
   } trace_tag_t;

   function automatic cls_e classify(input logic [31:0] instr);
      logic [5:0] op;
      logic [5:0] fn;
      cls_e       c;
      op = instr[31:26];
      fn = instr[5:0];
      c  = CLS_OTHER;
      if (op == OP_RTYPE) begin
         case (fn)
            FN_ADD:   c = CLS_ADD;
            FN_SUB:   c = CLS_SUB;
            FN_AND:   c = CLS_AND;
            FN_OR:    c = CLS_OR;
            FN_SLL:   c = (instr[25:11] == 15'd0) ? CLS_NOP : CLS_SLL;
            FN_MULTU: c = CLS_MULTU;
            FN_HI:    c = CLS_HI;
            FN_LO:    c = CLS_LO;
            default:  c = CLS_OTHER;
         endcase
      end else begin
         case (op)
            OP_LW:   c = CLS_LW;
            OP_SW:   c = CLS_SW;
            OP_BEQ:  c = CLS_BEQ;
            OP_J:    c = CLS_J;
            OP_JR:   c = CLS_JR;
            OP_ANDI: c = CLS_ANDI;
            default: c = CLS_OTHER;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/pipe_trace_unit_ring.sv
// Circular trace store: DEPTH entries of W bits with read/write pointers, fill count,
// full-buffer overwrite-or-drop policy and a sticky overflow flag.
module trace_ring #(
   parameter int DEPTH = 16,
   parameter int W     = 8,
   parameter int WRAP  = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         rd_valid,
   output logic [W-1:0] rd_data,
   output logic         overflow
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          full;
   logic          do_pop;
   logic          we;

   assign rd_valid = (count != '0);
   assign rd_data  = mem[rd_ptr];
   assign full     = (count == (PW+1)'(DEPTH));
   assign do_pop   = pop && rd_valid;
   // A full buffer still accepts a write when the head leaves on the same edge
   // or when overwriting the oldest entry is allowed.
   assign we       = push && !clear && (!full || do_pop || (WRAP != 0));

   always_ff @(posedge clk) begin
      if (we) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (push && full && !do_pop) begin
         overflow <= 1'b1;
         if (WRAP != 0) begin
            wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr + 1'b1;
         end
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/pipe_trace_unit.sv
// Retirement-trace and instruction-class profiler sitting beside the pipeline:
// run-control FSM with cycle budget, classifier, saturating class counters, trace ring.
//
// state   | meaning
// IDLE    | after reset, nothing captured, counters frozen
// RUN     | capturing retirements, cycle_cnt advancing
// DONE    | stopped by stop or budget, counters frozen, ring still drainable
module pipe_trace_unit
   import pipe_trace_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 200,
   parameter int WRAP       = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              ret_valid,
   input  logic [DATA_W-1:0] ret_pc,
   input  logic [31:0]       ret_instr,
   input  logic [DATA_W-1:0] ret_wd,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_pc,
   output logic [31:0]       rd_instr,
   output logic [DATA_W-1:0] rd_wd,
   output logic [CNT_W-1:0]  rd_cycle,
   output logic [3:0]        rd_class,
   input  logic [3:0]        cnt_sel,
   output logic [CNT_W-1:0]  cnt_val,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic              running,
   output logic              done,
   output logic              overflow
);

   localparam int TAG_W = $bits(trace_tag_t);
   localparam int ENT_W = 2*DATA_W + CNT_W + TAG_W;
   localparam logic [CNT_W-1:0] BUDGET = CNT_W'(MAX_CYCLES);

   state_e           state;
   logic [CNT_W-1:0] cls_cnt [16];
   logic [CNT_W-1:0] cycle_nxt;
   logic             budget_hit;
   logic             capture;
   cls_e             cap_cls;
   trace_tag_t       cap_tag;
   trace_tag_t       head_tag;
   logic [ENT_W-1:0] push_data;
   logic [ENT_W-1:0] head_data;

   assign cap_cls    = classify(ret_instr);
   // start clears on its edge, so a retirement on that same edge is not kept
   assign capture    = (state == ST_RUN) && ret_valid && !start;
   assign cycle_nxt  = cycle_cnt + 1'b1;
   assign budget_hit = (MAX_CYCLES != 0) && (cycle_nxt == BUDGET);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cycle_cnt <= '0;
      end else if (start) begin
         state     <= ST_RUN;
         cycle_cnt <= '0;
      end else if (state == ST_RUN) begin
         cycle_cnt <= cycle_nxt;
         if (stop || budget_hit) state <= ST_DONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) cls_cnt[i] <= '0;
      end else if (start) begin
         for (int i = 0; i < 16; i++) cls_cnt[i] <= '0;
      end else if (capture && (cls_cnt[cap_cls] != '1)) begin
         cls_cnt[cap_cls] <= cls_cnt[cap_cls] + 1'b1;
      end
   end

   assign cnt_val = cls_cnt[cnt_sel];
   assign running = (state == ST_RUN);
   assign done    = (state == ST_DONE);

   assign cap_tag   = '{instr: ret_instr, cls: cap_cls};
   assign push_data = {ret_pc, ret_wd, cycle_cnt, cap_tag};

   trace_ring #(
      .DEPTH (DEPTH),
      .W     (ENT_W),
      .WRAP  (WRAP)
   ) u_ring (
      .clk       (clk),
      .rst       (rst),
      .clear     (start),
      .push      (capture),
      .push_data (push_data),
      .pop       (rd_ready),
      .rd_valid  (rd_valid),
      .rd_data   (head_data),
      .overflow  (overflow)
   );

   assign {rd_pc, rd_wd, rd_cycle, head_tag} = head_data;
   assign rd_instr = head_tag.instr;
   assign rd_class = head_tag.cls;

endmodule

// File: tb/tb_pipe_trace_unit.sv
// Scoreboard bench for pipe_trace_unit: three instances (default, DEPTH=4 overwrite,
// DEPTH=4 drop) share the retirement stream; each test owns its own checks.
module tb_pipe_trace_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        ret_valid = 1'b0;
   logic [31:0] ret_pc = '0;
   logic [31:0] ret_instr = '0;
   logic [31:0] ret_wd = '0;
   logic [3:0]  cnt_sel = '0;
   logic        rdy_m = 1'b0;
   logic        rdy_a = 1'b0;
   logic        rdy_b = 1'b0;

   logic        m_rd_valid, a_rd_valid, b_rd_valid;
   logic [31:0] m_rd_pc, a_rd_pc, b_rd_pc;
   logic [31:0] m_rd_instr, a_rd_instr, b_rd_instr;
   logic [31:0] m_rd_wd, a_rd_wd, b_rd_wd;
   logic [31:0] m_rd_cycle, a_rd_cycle, b_rd_cycle;
   logic [3:0]  m_rd_class, a_rd_class, b_rd_class;
   logic [31:0] m_cnt_val, a_cnt_val, b_cnt_val;
   logic [31:0] m_cycle_cnt, a_cycle_cnt, b_cycle_cnt;
   logic        m_running, a_running, b_running;
   logic        m_done, a_done, b_done;
   logic        m_overflow, a_overflow, b_overflow;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] wd;
      logic [31:0] cyc;
      logic [3:0]  cls;
   } exp_t;

   exp_t q_m[$];
   exp_t q_a[$];
   exp_t q_b[$];
   int   total = 0;
   int   bad = 0;

   localparam logic [31:0] I_ADD  = 32'h0022_1820;
   localparam logic [31:0] I_LW   = 32'h8C43_0004;
   localparam logic [31:0] I_NOP  = 32'h0000_0000;
   localparam logic [31:0] I_ANDI = 32'h3042_000F;
   localparam logic [31:0] I_SW   = 32'hAC43_0000;

   pipe_trace_unit #(.DEPTH(16), .DATA_W(32), .CNT_W(32), .MAX_CYCLES(200), .WRAP(1)) u_main (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .ret_valid(ret_valid),
      .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_wd(ret_wd),
      .rd_valid(m_rd_valid), .rd_ready(rdy_m), .rd_pc(m_rd_pc), .rd_instr(m_rd_instr),
      .rd_wd(m_rd_wd), .rd_cycle(m_rd_cycle), .rd_class(m_rd_class), .cnt_sel(cnt_sel),
      .cnt_val(m_cnt_val), .cycle_cnt(m_cycle_cnt), .running(m_running), .done(m_done),
      .overflow(m_overflow));

   pipe_trace_unit #(.DEPTH(4), .DATA_W(32), .CNT_W(32), .MAX_CYCLES(0), .WRAP(1)) u_wrap (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .ret_valid(ret_valid),
      .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_wd(ret_wd),
      .rd_valid(a_rd_valid), .rd_ready(rdy_a), .rd_pc(a_rd_pc), .rd_instr(a_rd_instr),
      .rd_wd(a_rd_wd), .rd_cycle(a_rd_cycle), .rd_class(a_rd_class), .cnt_sel(cnt_sel),
      .cnt_val(a_cnt_val), .cycle_cnt(a_cycle_cnt), .running(a_running), .done(a_done),
      .overflow(a_overflow));

   pipe_trace_unit #(.DEPTH(4), .DATA_W(32), .CNT_W(32), .MAX_CYCLES(0), .WRAP(0)) u_drop (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .ret_valid(ret_valid),
      .ret_pc(ret_pc), .ret_instr(ret_instr), .ret_wd(ret_wd),
      .rd_valid(b_rd_valid), .rd_ready(rdy_b), .rd_pc(b_rd_pc), .rd_instr(b_rd_instr),
      .rd_wd(b_rd_wd), .rd_cycle(b_rd_cycle), .rd_class(b_rd_class), .cnt_sel(cnt_sel),
      .cnt_val(b_cnt_val), .cycle_cnt(b_cycle_cnt), .running(b_running), .done(b_done),
      .overflow(b_overflow));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] wd);
      ret_valid = 1'b1;
      ret_pc    = pc;
      ret_instr = instr;
      ret_wd    = wd;
      tick();
      ret_valid = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      total++;
      if (m_rd_valid !== 1'b0 || m_cycle_cnt !== 32'd0 || m_running !== 1'b0 ||
          m_done !== 1'b0 || m_overflow !== 1'b0 || m_cnt_val !== 32'd0) begin
         bad++;
         $display("FAIL reset_state got v=%b cyc=%0d run=%b done=%b ovf=%b cnt=%0d want all 0",
                  m_rd_valid, m_cycle_cnt, m_running, m_done, m_overflow, m_cnt_val);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      exp_t e;
      do_start();
      total++;
      if (m_running !== 1'b1 || m_rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL start_state got run=%b v=%b want run=1 v=0", m_running, m_rd_valid);
      end
      q_m.push_back('{pc: 32'd0, instr: I_ADD, wd: 32'h11, cyc: 32'd0, cls: 4'd0});
      retire(32'd0, I_ADD, 32'h11);
      total++;
      if (m_rd_valid !== 1'b1) begin
         bad++;
         $display("FAIL first_capture_valid got=%b want=1", m_rd_valid);
      end
      q_m.push_back('{pc: 32'd4, instr: I_LW, wd: 32'h22, cyc: 32'd1, cls: 4'd9});
      retire(32'd4, I_LW, 32'h22);
      q_m.push_back('{pc: 32'd8, instr: I_NOP, wd: 32'h0, cyc: 32'd2, cls: 4'd5});
      retire(32'd8, I_NOP, 32'h0);
      cnt_sel = 4'd9;
      #1;
      total++;
      if (m_cnt_val !== 32'd1) begin
         bad++;
         $display("FAIL cnt_lw got=%0d want=1", m_cnt_val);
      end
      cnt_sel = 4'd4;
      #1;
      total++;
      if (m_cnt_val !== 32'd0) begin
         bad++;
         $display("FAIL cnt_sll got=%0d want=0", m_cnt_val);
      end
      for (int k = 0; k < 3; k++) begin
         e = q_m.pop_front();
         total++;
         if (m_rd_valid !== 1'b1 || m_rd_pc !== e.pc || m_rd_instr !== e.instr ||
             m_rd_wd !== e.wd || m_rd_cycle !== e.cyc || m_rd_class !== e.cls) begin
            bad++;
            $display("FAIL basic_drain[%0d] got v=%b pc=%h ins=%h wd=%h cyc=%0d cls=%0d want pc=%h ins=%h wd=%h cyc=%0d cls=%0d",
                     k, m_rd_valid, m_rd_pc, m_rd_instr, m_rd_wd, m_rd_cycle, m_rd_class,
                     e.pc, e.instr, e.wd, e.cyc, e.cls);
         end
         rdy_m = 1'b1;
         tick();
         rdy_m = 1'b0;
      end
      total++;
      if (m_rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_empty got=%b want=0", m_rd_valid);
      end
   endtask

   task automatic test_stop();
      exp_t e;
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (m_running !== 1'b1 || m_cycle_cnt !== 32'd0 || m_rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL start_over_stop got run=%b cyc=%0d v=%b want run=1 cyc=0 v=0",
                  m_running, m_cycle_cnt, m_rd_valid);
      end
      q_m.push_back('{pc: 32'h40, instr: I_ANDI, wd: 32'h5, cyc: 32'd0, cls: 4'd14});
      retire(32'h40, I_ANDI, 32'h5);
      stop = 1'b0;
      total++;
      if (m_done !== 1'b1 || m_running !== 1'b0 || m_cycle_cnt !== 32'd1) begin
         bad++;
         $display("FAIL stop_state got done=%b run=%b cyc=%0d want done=1 run=0 cyc=1",
                  m_done, m_running, m_cycle_cnt);
      end
      retire(32'h44, I_SW, 32'h6);
      tick();
      cnt_sel = 4'd10;
      #1;
      total++;
      if (m_cnt_val !== 32'd0 || m_cycle_cnt !== 32'd1) begin
         bad++;
         $display("FAIL done_frozen got sw=%0d cyc=%0d want sw=0 cyc=1", m_cnt_val, m_cycle_cnt);
      end
      cnt_sel = 4'd14;
      #1;
      total++;
      if (m_cnt_val !== 32'd1) begin
         bad++;
         $display("FAIL cnt_andi got=%0d want=1", m_cnt_val);
      end
      e = q_m.pop_front();
      total++;
      if (m_rd_valid !== 1'b1 || m_rd_pc !== e.pc || m_rd_cycle !== e.cyc || m_rd_class !== e.cls) begin
         bad++;
         $display("FAIL stop_edge_capture got v=%b pc=%h cyc=%0d cls=%0d want pc=%h cyc=%0d cls=%0d",
                  m_rd_valid, m_rd_pc, m_rd_cycle, m_rd_class, e.pc, e.cyc, e.cls);
      end
      rdy_m = 1'b1;
      tick();
      rdy_m = 1'b0;
      total++;
      if (m_rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL done_no_capture got v=%b want=0", m_rd_valid);
      end
   endtask

   task automatic test_budget();
      do_start();
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (i == 199) begin
            total++;
            if (m_done !== 1'b0 || m_running !== 1'b1) begin
               bad++;
               $display("FAIL budget_early got done=%b run=%b want done=0 run=1", m_done, m_running);
            end
         end
      end
      total++;
      if (m_done !== 1'b1 || m_running !== 1'b0 || m_cycle_cnt !== 32'd200) begin
         bad++;
         $display("FAIL budget_end got done=%b run=%b cyc=%0d want done=1 run=0 cyc=200",
                  m_done, m_running, m_cycle_cnt);
      end
      retire(32'h80, I_ADD, 32'h1);
      tick();
      total++;
      if (m_rd_valid !== 1'b0 || m_cycle_cnt !== 32'd200) begin
         bad++;
         $display("FAIL budget_frozen got v=%b cyc=%0d want v=0 cyc=200", m_rd_valid, m_cycle_cnt);
      end
   endtask

   task automatic test_wrap_drop();
      exp_t e;
      do_start();
      for (int i = 0; i < 6; i++) begin
         e = '{pc: 32'(4*i), instr: I_ADD, wd: 32'(i), cyc: 32'(i), cls: 4'd0};
         if (q_a.size() == 4) void'(q_a.pop_front());
         q_a.push_back(e);
         if (q_b.size() < 4) q_b.push_back(e);
         retire(e.pc, e.instr, e.wd);
         if (i == 3) begin
            total++;
            if (a_overflow !== 1'b0 || b_overflow !== 1'b0) begin
               bad++;
               $display("FAIL full_no_ovf got a=%b b=%b want 0 0", a_overflow, b_overflow);
            end
         end
      end
      cnt_sel = 4'd0;
      #1;
      total++;
      if (a_overflow !== 1'b1 || b_overflow !== 1'b1 || a_cnt_val !== 32'd6 || b_cnt_val !== 32'd6) begin
         bad++;
         $display("FAIL ovf_counts got ovf=%b%b cnt=%0d/%0d want ovf=11 cnt=6/6",
                  a_overflow, b_overflow, a_cnt_val, b_cnt_val);
      end
      for (int k = 0; k < 4; k++) begin
         e = q_a.pop_front();
         total++;
         if (a_rd_valid !== 1'b1 || a_rd_pc !== e.pc || a_rd_cycle !== e.cyc || a_rd_wd !== e.wd) begin
            bad++;
            $display("FAIL wrap_drain[%0d] got v=%b pc=%0d cyc=%0d wd=%0d want pc=%0d cyc=%0d wd=%0d",
                     k, a_rd_valid, a_rd_pc, a_rd_cycle, a_rd_wd, e.pc, e.cyc, e.wd);
         end
         rdy_a = 1'b1;
         tick();
         rdy_a = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
         e = q_b.pop_front();
         total++;
         if (b_rd_valid !== 1'b1 || b_rd_pc !== e.pc || b_rd_cycle !== e.cyc || b_rd_wd !== e.wd) begin
            bad++;
            $display("FAIL drop_drain[%0d] got v=%b pc=%0d cyc=%0d wd=%0d want pc=%0d cyc=%0d wd=%0d",
                     k, b_rd_valid, b_rd_pc, b_rd_cycle, b_rd_wd, e.pc, e.cyc, e.wd);
         end
         rdy_b = 1'b1;
         tick();
         rdy_b = 1'b0;
      end
      total++;
      if (a_rd_valid !== 1'b0 || b_rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL wrap_drop_empty got a=%b b=%b want 0 0", a_rd_valid, b_rd_valid);
      end
   endtask

   task automatic test_full_pop();
      exp_t e;
      do_start();
      for (int i = 0; i < 4; i++) begin
         e = '{pc: 32'(64 + 4*i), instr: I_LW, wd: 32'(100 + i), cyc: 32'(i), cls: 4'd9};
         q_a.push_back(e);
         retire(e.pc, e.instr, e.wd);
      end
      e = q_a.pop_front();
      total++;
      if (a_rd_pc !== e.pc || a_overflow !== 1'b0) begin
         bad++;
         $display("FAIL full_head got pc=%0d ovf=%b want pc=%0d ovf=0", a_rd_pc, a_overflow, e.pc);
      end
      q_a.push_back('{pc: 32'd128, instr: I_SW, wd: 32'd200, cyc: 32'd4, cls: 4'd10});
      rdy_a = 1'b1;
      retire(32'd128, I_SW, 32'd200);
      rdy_a = 1'b0;
      total++;
      if (a_overflow !== 1'b0 || a_rd_pc !== q_a[0].pc) begin
         bad++;
         $display("FAIL full_pop_push got ovf=%b pc=%0d want ovf=0 pc=%0d", a_overflow, a_rd_pc, q_a[0].pc);
      end
      for (int k = 0; k < 4; k++) begin
         e = q_a.pop_front();
         total++;
         if (a_rd_valid !== 1'b1 || a_rd_pc !== e.pc || a_rd_cycle !== e.cyc || a_rd_class !== e.cls) begin
            bad++;
            $display("FAIL full_pop_drain[%0d] got v=%b pc=%0d cyc=%0d cls=%0d want pc=%0d cyc=%0d cls=%0d",
                     k, a_rd_valid, a_rd_pc, a_rd_cycle, a_rd_class, e.pc, e.cyc, e.cls);
         end
         rdy_a = 1'b1;
         tick();
         rdy_a = 1'b0;
      end
      rdy_a = 1'b1;
      tick();
      rdy_a = 1'b0;
      total++;
      if (a_rd_valid !== 1'b0) begin
         bad++;
         $display("FAIL empty_pop got v=%b want=0", a_rd_valid);
      end
      retire(32'd300, I_ADD, 32'd7);
      total++;
      if (a_rd_valid !== 1'b1 || a_rd_pc !== 32'd300) begin
         bad++;
         $display("FAIL after_empty_pop got v=%b pc=%0d want v=1 pc=300", a_rd_valid, a_rd_pc);
      end
   endtask

   task automatic test_async_reset();
      do_start();
      retire(32'd0, I_ADD, 32'd1);
      retire(32'd4, I_ADD, 32'd2);
      retire(32'd8, I_ADD, 32'd3);
      cnt_sel = 4'd0;
      #2;
      rst = 1'b0;
      #1;
      total++;
      if (m_rd_valid !== 1'b0 || m_cycle_cnt !== 32'd0 || m_cnt_val !== 32'd0 ||
          m_overflow !== 1'b0 || m_running !== 1'b0) begin
         bad++;
         $display("FAIL async_reset got v=%b cyc=%0d cnt=%0d ovf=%b run=%b want all 0",
                  m_rd_valid, m_cycle_cnt, m_cnt_val, m_overflow, m_running);
      end
      rst = 1'b1;
      tick();
      do_start();
      retire(32'h200, I_ADD, 32'd9);
      total++;
      if (m_rd_valid !== 1'b1 || m_rd_pc !== 32'h200 || m_rd_cycle !== 32'd0) begin
         bad++;
         $display("FAIL restart_after_reset got v=%b pc=%h cyc=%0d want v=1 pc=200 cyc=0",
                  m_rd_valid, m_rd_pc, m_rd_cycle);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stop();
      test_budget();
      test_wrap_drop();
      test_full_pop();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
